mem_port_arbiter: RTL

- Shares the single unified instruction/data memory port of the multicycle RISC-V core between two requesters.
- Requester 0 is the core's memory interface; it handles fetch and load/store addresses after the PC/ALU address mux.
- Requester 1 is the program loader / debug port.
- Round-robin arbitration, a fixed-latency memory access sequencer with a configurable wait-state count, and a req/done handshake; the core controller stalls its fetch/memory states until done.

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/mem_port_arbiter_rr_arbiter2.sv | 25 ++
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter.
// Holds the sequencer state encoding and the requester index constants.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-input round-robin pick: a lone requester wins outright, and on a tie
// the requester that was not granted last time wins.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);

  // Winner selection from the current requests and the previous grant
  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_idx = ~last_grant;
    end else if (req1) begin
      grant_idx = REQ_LOAD;
    end else begin
      grant_idx = REQ_CPU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between the core and the loader/debug
// port. Round-robin grant, LAT access cycles, then a one-cycle done pulse.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2,
  parameter int CW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          done0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          owner,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [CW-1:0] CNT_LAT = CW'(LAT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          we_r, we_s;
  logic [AW-1:0] addr_r, addr_s;
  logic [DW-1:0] wdata_r, wdata_s;
  logic [DW-1:0] rdata_r, rdata_s;
  logic          owner_r, owner_s;
  logic          last_grant_r, last_grant_s;
  logic          done0_r, done0_s;
  logic          done1_r, done1_s;
  logic          mem_en_r, mem_en_s;
  logic          mem_we_r, mem_we_s;
  logic          busy_r, busy_s;
  logic          grant_valid_s;
  logic          grant_idx_s;

  rr_arbiter2 u_rr (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant_r),
    .grant_valid (grant_valid_s),
    .grant_idx   (grant_idx_s)
  );

  // Next-state and next-output decode; every output is the registered copy
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    we_s         = we_r;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    rdata_s      = rdata_r;
    owner_s      = owner_r;
    last_grant_s = last_grant_r;
    done0_s      = 1'b0;
    done1_s      = 1'b0;
    mem_en_s     = 1'b0;
    mem_we_s     = 1'b0;
    busy_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_valid_s) begin
          state_s = ST_ACCESS;
          cnt_s   = CNT_LAT;
          owner_s = grant_idx_s;
          if (grant_idx_s == REQ_LOAD) begin
            we_s    = we1;
            addr_s  = addr1;
            wdata_s = wdata1;
          end else begin
            we_s    = we0;
            addr_s  = addr0;
            wdata_s = wdata0;
          end
          mem_en_s = 1'b1;
          mem_we_s = we_s;
          busy_s   = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        busy_s = 1'b1;
        cnt_s  = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          state_s = ST_RESP;
          // Writes leave the read-data register untouched
          if (!we_r) begin
            rdata_s = mem_rdata;
          end else begin
            rdata_s = rdata_r;
          end
          if (owner_r == REQ_LOAD) begin
            done1_s = 1'b1;
          end else begin
            done0_s = 1'b1;
          end
        end else begin
          mem_en_s = 1'b1;
          mem_we_s = we_r;
        end
      end
      ST_RESP: begin
        state_s      = ST_IDLE;
        last_grant_s = owner_r;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counter, latched request and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CW{1'b0}};
      we_r         <= 1'b0;
      addr_r       <= {AW{1'b0}};
      wdata_r      <= {DW{1'b0}};
      rdata_r      <= {DW{1'b0}};
      owner_r      <= REQ_LOAD;
      last_grant_r <= REQ_LOAD;
      done0_r      <= 1'b0;
      done1_r      <= 1'b0;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      we_r         <= we_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      rdata_r      <= rdata_s;
      owner_r      <= owner_s;
      last_grant_r <= last_grant_s;
      done0_r      <= done0_s;
      done1_r      <= done1_s;
      mem_en_r     <= mem_en_s;
      mem_we_r     <= mem_we_s;
      busy_r       <= busy_s;
    end
  end

  assign done0     = done0_r;
  assign done1     = done1_r;
  assign rdata     = rdata_r;
  assign owner     = owner_r;
  assign busy      = busy_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;

endmodule
